// File: rtl/splitter_pkg.sv
// splitter_pkg: shared phase encoding and config addresses for the splitter window scheduler
package splitter_pkg;
  typedef enum logic [1:0] {
    PH_STOP   = 2'd0,
    PH_ACTIVE = 2'd1,
    PH_IDLE   = 2'd2,
    PH_DRAIN  = 2'd3
  } phase_t;
  localparam logic CFG_ACTIVE_LEN = 1'b0;
  localparam logic CFG_IDLE_LEN   = 1'b1;
endpackage

// File: rtl/splitter_cfg_regs.sv
// splitter_cfg_regs: pending/working window lengths with write validation and sticky error
module splitter_cfg_regs
  import splitter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16,
  parameter int DEF_ACTIVE = 3276,
  parameter int DEF_IDLE   = 1172
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cfg_wr,
  input  logic                 i_cfg_addr,
  input  logic [CNT_WIDTH-1:0] i_cfg_wdata,
  input  logic                 i_commit,
  output logic [CNT_WIDTH-1:0] o_act_len,
  output logic [CNT_WIDTH-1:0] o_idl_len,
  output logic                 o_cfg_err
);
  localparam logic [63:0] DEPTH = 64'd1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] RST_ACT = CNT_WIDTH'(DEF_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] RST_IDL = CNT_WIDTH'(DEF_IDLE);
  logic                 w_reject, w_accept;
  logic [CNT_WIDTH-1:0] r_pend_act, r_pend_idl, r_act, r_idl;
  logic                 r_err;
  assign w_reject  = i_cfg_wr && (i_cfg_wdata == '0 ||
                     (i_cfg_addr == CFG_IDLE_LEN && 64'(i_cfg_wdata) > DEPTH));
  assign w_accept  = i_cfg_wr && !w_reject;
  assign o_act_len = r_act;
  assign o_idl_len = r_idl;
  assign o_cfg_err = r_err;
  // Validated writes land in the pending pair; rejected writes only raise the sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend_act <= RST_ACT;
      r_pend_idl <= RST_IDL;
      r_err      <= 1'b0;
    end else begin
      if (w_accept && i_cfg_addr == CFG_ACTIVE_LEN) r_pend_act <= i_cfg_wdata;
      if (w_accept && i_cfg_addr == CFG_IDLE_LEN) r_pend_idl <= i_cfg_wdata;
      if (w_reject) r_err <= 1'b1;
    end
  // Commit copies the pre-write pending values, so a same-cycle write waits one more frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_act <= RST_ACT;
      r_idl <= RST_IDL;
    end else if (i_commit) begin
      r_act <= r_pend_act;
      r_idl <= r_pend_idl;
    end
endmodule

// File: rtl/splitter_window_scheduler.sv
// splitter_window_scheduler: sequences the 64->2x32 splitter through ACTIVE/IDLE/DRAIN windows
module splitter_window_scheduler
  import splitter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16,
  parameter int DEF_ACTIVE = 3276,
  parameter int DEF_IDLE   = 1172
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_valid_in,
  input  logic                  i_cfg_wr,
  input  logic                  i_cfg_addr,
  input  logic [CNT_WIDTH-1:0]  i_cfg_wdata,
  output logic [1:0]            o_phase,
  output logic                  o_buf_wr_en,
  output logic [ADDR_WIDTH-1:0] o_buf_wr_addr,
  output logic                  o_buf_rd_en,
  output logic [ADDR_WIDTH-1:0] o_buf_rd_addr,
  output logic                  o_frame_start,
  output logic [15:0]           o_frame_count,
  output logic                  o_cfg_err
);
  localparam logic [CNT_WIDTH-1:0]  ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AONE = ADDR_WIDTH'(1);
  phase_t                r_state, w_next;
  logic                  w_commit, w_last;
  logic [CNT_WIDTH-1:0]  w_act_len, w_idl_len, r_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr, r_buf_wr_addr, r_buf_rd_addr;
  logic                  r_buf_wr_en, r_buf_rd_en, r_frame_start;
  logic [15:0]           r_frame_count;

  splitter_cfg_regs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .DEF_ACTIVE (DEF_ACTIVE),
    .DEF_IDLE   (DEF_IDLE)
  ) u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_wr    (i_cfg_wr),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_wdata (i_cfg_wdata),
    .i_commit    (w_commit),
    .o_act_len   (w_act_len),
    .o_idl_len   (w_idl_len),
    .o_cfg_err   (o_cfg_err)
  );

  assign w_last        = r_cnt == ((r_state == PH_ACTIVE ? w_act_len : w_idl_len) - ONE);
  assign o_phase       = r_state;
  assign o_buf_wr_en   = r_buf_wr_en;
  assign o_buf_wr_addr = r_buf_wr_addr;
  assign o_buf_rd_en   = r_buf_rd_en;
  assign o_buf_rd_addr = r_buf_rd_addr;
  assign o_frame_start = r_frame_start;
  assign o_frame_count = r_frame_count;

  // Window state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= PH_STOP;
    else r_state <= w_next;

  // Next window and commit: a window only ends on its last accepted sample
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      PH_STOP: if (i_enable) begin
        w_next   = PH_ACTIVE;
        w_commit = 1'b1;
      end
      PH_ACTIVE: if (i_valid_in && w_last) w_next = PH_IDLE;
      PH_IDLE: if (i_valid_in && w_last) w_next = PH_DRAIN;
      default: if (i_valid_in && w_last) begin
        w_next   = i_enable ? PH_ACTIVE : PH_STOP;
        w_commit = 1'b1;
      end
    endcase
  end

  // Sample counter, buffer pointers, registered strobes and frame status
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_buf_wr_addr <= '0;
      r_buf_rd_addr <= '0;
      r_buf_wr_en   <= 1'b0;
      r_buf_rd_en   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_buf_wr_en   <= 1'b0;
      r_buf_rd_en   <= 1'b0;
      r_frame_start <= 1'b0;
      if (r_state == PH_STOP) r_cnt <= '0;
      else if (i_valid_in) begin
        r_cnt <= w_last ? '0 : r_cnt + ONE;
        case (r_state)
          PH_ACTIVE: begin
            r_frame_start <= r_cnt == '0;
            if (w_last) r_wr_ptr <= '0;
          end
          PH_IDLE: begin
            r_buf_wr_en   <= 1'b1;
            r_buf_wr_addr <= r_wr_ptr;
            r_wr_ptr      <= r_wr_ptr + AONE;
            if (w_last) r_rd_ptr <= '0;
          end
          default: begin
            r_buf_rd_en   <= 1'b1;
            r_buf_rd_addr <= r_rd_ptr;
            r_rd_ptr      <= r_rd_ptr + AONE;
            if (w_last) r_frame_count <= r_frame_count + 16'd1;
          end
        endcase
      end
    end
endmodule
